// File: rtl/cluster_clock_divider_ctrl.sv
// cluster_clock_divider_ctrl
//   Programmable integer clock divider for the cluster clock tree. It produces
//   a registered divided clock and a one-root-cycle enable pulse per divided
//   period. The divide ratio is changed at runtime through a valid/ack
//   handshake. A new ratio is applied only on a period boundary, so the
//   divided clock never produces a runt pulse.
//
// Ports
//   clk_i        root clock
//   rst_i        synchronous reset, active-high
//   div_i        requested divide ratio N (0 and 1 select bypass)
//   div_valid_i  request valid, held by the requester until div_ack_o
//   div_ack_o    one-cycle acknowledge, high in the first cycle of the new ratio
//   clk_en_o     high in the last root cycle of each divided period
//   clk_div_o    registered divided clock
//   busy_o       high while a captured request waits for a period boundary
module cluster_clock_divider_ctrl #(
   parameter int DIV_WIDTH   = 8,
   parameter int DEFAULT_DIV = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [DIV_WIDTH-1:0] div_i,
   input  logic                 div_valid_i,
   output logic                 div_ack_o,
   output logic                 clk_en_o,
   output logic                 clk_div_o,
   output logic                 busy_o
);

   localparam logic [DIV_WIDTH-1:0] DEFAULT_DIV_W = DIV_WIDTH'(DEFAULT_DIV);
   localparam logic [DIV_WIDTH-1:0] ONE_W         = DIV_WIDTH'(1);
   localparam logic [DIV_WIDTH-1:0] TWO_W         = DIV_WIDTH'(2);
   localparam logic                 DEFAULT_CLK   = (DEFAULT_DIV >= 2);

   typedef enum logic [1:0] {
      IDLE,
      PENDING,
      ACK
   } state_t;

   state_t               state_reg;
   logic [DIV_WIDTH-1:0] div_reg;
   logic [DIV_WIDTH-1:0] pend_reg;
   logic [DIV_WIDTH-1:0] cnt_reg;
   logic                 clk_div_reg;

   logic [DIV_WIDTH-1:0] div_last;
   logic [DIV_WIDTH-1:0] half_last;
   logic                 bypass;
   logic                 boundary;

   // Ratios 0 and 1 pass the root clock through as a constant enable.
   assign bypass    = (div_reg < TWO_W);
   assign div_last  = div_reg - ONE_W;
   // Last cycle of the high phase; only meaningful when not in bypass.
   assign half_last = (div_reg >> 1) - ONE_W;
   assign boundary  = bypass | (cnt_reg == div_last);

   assign clk_en_o  = boundary;
   assign clk_div_o = clk_div_reg;
   assign busy_o    = (state_reg == PENDING);
   assign div_ack_o = (state_reg == ACK);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg   <= IDLE;
         div_reg     <= DEFAULT_DIV_W;
         pend_reg    <= '0;
         cnt_reg     <= '0;
         clk_div_reg <= DEFAULT_CLK;
      end else begin
         // Counter and divided clock. Applying a new ratio restarts the
         // period exactly as a natural wrap would, so the high phase of the
         // new ratio starts cleanly.
         if (state_reg == PENDING && boundary) begin
            div_reg     <= pend_reg;
            cnt_reg     <= '0;
            clk_div_reg <= (pend_reg >= TWO_W);
         end else if (bypass) begin
            cnt_reg     <= '0;
            clk_div_reg <= 1'b0;
         end else if (cnt_reg == div_last) begin
            cnt_reg     <= '0;
            clk_div_reg <= 1'b1;
         end else begin
            cnt_reg <= cnt_reg + ONE_W;
            if (cnt_reg == half_last) begin
               clk_div_reg <= 1'b0;
            end
         end

         // Request handshake. div_valid_i is ignored during ACK so a
         // requester that is slow to drop valid is not acknowledged twice
         // for the same boundary.
         case (state_reg)
            IDLE: begin
               if (div_valid_i) begin
                  pend_reg  <= div_i;
                  state_reg <= PENDING;
               end
            end
            PENDING: begin
               if (boundary) begin
                  state_reg <= ACK;
               end
            end
            ACK: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cluster_clock_divider_ctrl.sv
module tb_cluster_clock_divider_ctrl;

   localparam int W   = 8;
   localparam int DEF = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] div_in;
   logic         valid;
   logic         div_ack;
   logic         clk_en;
   logic         clk_div;
   logic         busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model: active ratio, position inside the current period,
   // captured request and handshake flags.
   int m_n;
   int m_pos;
   int m_pend;
   bit m_busy;
   bit m_ack;

   cluster_clock_divider_ctrl #(
      .DIV_WIDTH  (W),
      .DEFAULT_DIV(DEF)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .div_i      (div_in),
      .div_valid_i(valid),
      .div_ack_o  (div_ack),
      .clk_en_o   (clk_en),
      .clk_div_o  (clk_div),
      .busy_o     (busy)
   );

   always #5 clk = ~clk;

   // Expected {ack, clk_en, clk_div, busy} for the current cycle.
   // Divided clock is high for the first floor(N/2) cycles of each period.
   function automatic logic [3:0] model_out();
      logic en;
      logic dv;
      en = (m_n < 2) || (m_pos == m_n - 1);
      dv = (m_n >= 2) && (m_pos < m_n / 2);
      return {m_ack, en, dv, m_busy};
   endfunction

   function automatic logic [3:0] dut_out();
      return {div_ack, clk_en, clk_div, busy};
   endfunction

   // Advance one root cycle and step the model with the inputs seen at the edge.
   task automatic tick();
      logic [3:0] e;
      e = model_out();
      @(posedge clk);
      if (rst) begin
         m_n = DEF; m_pos = 0; m_busy = 0; m_ack = 0;
      end else if (m_busy && e[2]) begin
         m_n = m_pend; m_pos = 0; m_busy = 0; m_ack = 1;
         $display("txn: cycle %0d ratio %0d applied", cyc + 1, m_n);
      end else begin
         m_pos = (m_n < 2) ? 0 : (m_pos + 1) % m_n;
         if (m_ack) begin
            m_ack = 0;
         end else if (!m_busy && valid) begin
            m_busy = 1;
            m_pend = int'(div_in);
         end
      end
      cyc++;
      #1;
   endtask

   task automatic test_reset();
      rst = 1; valid = 0; div_in = '0;
      tick(); tick();
      checks++;
      if (dut_out() !== 4'b0010) begin
         errors++;
         $display("FAIL reset_state: got ack/en/div/busy=%b required 0010", dut_out());
      end
      rst = 0;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (clk_div !== ((i % 2) == 0) || dut_out() !== model_out()) begin
            errors++;
            $display("FAIL reset_div2 cyc %0d: got %b required %b", cyc, dut_out(), model_out());
         end
         tick();
      end
   endtask

   // A sequence of directed and random ratios; div_i is scrambled while the
   // request is pending and valid is dropped 0..2 cycles after the ack.
   task automatic test_ratio_change();
      int seq[$];
      int n;
      int hold;
      bit seen;
      seq = '{4, 3, 5, 0, 6, 4, 4, 1, 7, 2, 0, 0};
      for (int r = 0; r < 10; r++) seq.push_back(int'($urandom_range(0, 12)));
      foreach (seq[k]) begin
         n = seq[k];
         for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
            checks++;
            if (dut_out() !== model_out()) begin
               errors++;
               $display("FAIL ratio_idle cyc %0d: got %b required %b", cyc, dut_out(), model_out());
            end
            tick();
         end
         valid = 1; div_in = W'(n);
         seen = 0;
         for (int i = 0; i < 600 && !seen; i++) begin
            if (m_busy && $urandom_range(0, 1) == 1) div_in = W'($urandom);
            tick();
            checks++;
            if (dut_out() !== model_out()) begin
               errors++;
               $display("FAIL ratio_req n=%0d cyc %0d: got %b required %b", n, cyc, dut_out(), model_out());
            end
            seen = m_ack;
         end
         if (!seen) begin
            errors++;
            $display("FAIL ratio_timeout n=%0d: got no ack required ack within 600 cycles", n);
         end
         div_in = W'(n);
         hold = int'($urandom_range(0, 2));
         for (int i = 0; i < hold; i++) tick();
         valid = 0;
      end
      // Observe the settled ratio for a few periods.
      for (int i = 0; i < 40; i++) begin
         tick();
         checks++;
         if (dut_out() !== model_out()) begin
            errors++;
            $display("FAIL ratio_run cyc %0d: got %b required %b", cyc, dut_out(), model_out());
         end
      end
   endtask

   // From bypass, a request is acknowledged exactly two cycles after valid.
   task automatic test_bypass_latency();
      int lat;
      valid = 1; div_in = 8'd0;
      for (int i = 0; i < 40 && !m_ack; i++) tick();
      tick();
      valid = 0;
      tick(); tick();
      valid = 1; div_in = 8'd6;
      lat = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         lat++;
         checks++;
         if (dut_out() !== model_out()) begin
            errors++;
            $display("FAIL bypass_seq cyc %0d: got %b required %b", cyc, dut_out(), model_out());
         end
         if (div_ack === 1'b1) break;
      end
      valid = 0;
      checks++;
      if (lat !== 2) begin
         errors++;
         $display("FAIL bypass_latency: got %0d cycles required 2", lat);
      end
      for (int i = 0; i < 14; i++) begin
         tick();
         checks++;
         if (dut_out() !== model_out()) begin
            errors++;
            $display("FAIL bypass_run cyc %0d: got %b required %b", cyc, dut_out(), model_out());
         end
      end
   endtask

   // Valid never drops: each new ratio is presented during the ACK cycle and
   // captured the cycle after.
   task automatic test_back_to_back();
      int acks;
      valid = 1; div_in = W'($urandom_range(0, 9));
      acks = 0;
      for (int i = 0; i < 400 && acks < 30; i++) begin
         tick();
         checks++;
         if (dut_out() !== model_out()) begin
            errors++;
            $display("FAIL b2b cyc %0d: got %b required %b", cyc, dut_out(), model_out());
         end
         if (m_ack) begin
            acks++;
            div_in = W'($urandom_range(0, 9));
         end
      end
      valid = 0;
      checks++;
      if (acks < 30) begin
         errors++;
         $display("FAIL b2b_count: got %0d acks required 30", acks);
      end
   endtask

   // Largest ratio the counter width allows.
   task automatic test_max_div();
      valid = 1; div_in = 8'd255;
      for (int i = 0; i < 600 && !m_ack; i++) tick();
      valid = 0;
      for (int i = 0; i < 520; i++) begin
         checks++;
         if (dut_out() !== model_out()) begin
            errors++;
            $display("FAIL max_div cyc %0d: got %b required %b", cyc, dut_out(), model_out());
         end
         tick();
      end
   endtask

   // Reset while a request is pending discards it without an ack.
   task automatic test_reset_pending();
      int stray;
      valid = 1; div_in = 8'd4;
      for (int i = 0; i < 600 && !m_ack; i++) tick();
      valid = 0;
      tick(); tick();
      valid = 1; div_in = 8'd8;
      tick();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL rstpend_busy: got %b required 1", busy);
      end
      rst = 1;
      tick();
      rst = 0; valid = 0;
      checks++;
      if (dut_out() !== 4'b0010) begin
         errors++;
         $display("FAIL rstpend_state: got ack/en/div/busy=%b required 0010", dut_out());
      end
      stray = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (div_ack === 1'b1) stray++;
         checks++;
         if (dut_out() !== model_out()) begin
            errors++;
            $display("FAIL rstpend_run cyc %0d: got %b required %b", cyc, dut_out(), model_out());
         end
      end
      checks++;
      if (stray !== 0) begin
         errors++;
         $display("FAIL rstpend_noack: got %0d acks required 0", stray);
      end
   endtask

   initial begin
      rst = 1; valid = 0; div_in = '0;
      m_n = DEF; m_pos = 0; m_pend = 0; m_busy = 0; m_ack = 0;
      test_reset();
      test_ratio_change();
      test_bypass_latency();
      test_back_to_back();
      test_max_div();
      test_reset_pending();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
